// File: rtl/pipelined_approx_adder.sv
// Pipelined approximate ripple-carry adder with valid/ready handshake.
// Define PIPELINED_APPROX_ADDER_ERR_CNT_EN to add the exact-shadow error counter.
module pipelined_approx_adder #(
    parameter int N          = 16,
    parameter int STAGES     = 2,
    parameter int APPROX_LSB = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    input  logic         exact_mode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         cout
`ifdef PIPELINED_APPROX_ADDER_ERR_CNT_EN
    ,
    input  logic         clr_err,
    output logic [15:0]  err_count
`endif
);

    localparam int W = N / STAGES;

    // Carry is always the exact majority; approximate cells only bend the sum bit.
    function automatic logic [W:0] add_slice(
        input logic [W-1:0] x,
        input logic [W-1:0] y,
        input logic         ci,
        input logic         ex,
        input int           base
    );
        logic [W-1:0] s;
        logic         c;
        logic         co;
        s  = '0;
        c  = ci;
        co = 1'b0;
        for (int i = 0; i < W; i++) begin
            co = (x[i] & y[i]) | (x[i] & c) | (y[i] & c);
            if (!ex && (base + i) < APPROX_LSB) begin
                s[i] = ~co;
            end else begin
                s[i] = x[i] ^ y[i] ^ c;
            end
            c = co;
        end
        return {c, s};
    endfunction

    for (genvar s = 0; s < STAGES; s++) begin : g_stg
        // Operand bits that later stages still have to add.
        localparam int RW = N - (s + 1) * W;

        logic [RW+W-1:0]    ua;
        logic [RW+W-1:0]    ub;
        logic               ci;
        logic               ex;
        logic               vin;
        logic               nxt;
        logic               adv;
        logic [W:0]         res;
        logic [(s+1)*W-1:0] s_d;
        logic               v_q;
        logic               c_q;
        logic [(s+1)*W-1:0] s_q;

        if (s == 0) begin : g_src
            assign ua  = a;
            assign ub  = b;
            assign ci  = cin;
            assign ex  = exact_mode;
            assign vin = in_valid;
            assign s_d = res[W-1:0];
        end else begin : g_src
            assign ua  = g_stg[s-1].g_fwd.a_q;
            assign ub  = g_stg[s-1].g_fwd.b_q;
            assign ci  = g_stg[s-1].c_q;
            assign ex  = g_stg[s-1].g_fwd.m_q;
            assign vin = g_stg[s-1].v_q;
            assign s_d = {res[W-1:0], g_stg[s-1].s_q};
        end

        if (s == STAGES - 1) begin : g_nxt
            assign nxt = out_ready;
        end else begin : g_nxt
            assign nxt = g_stg[s+1].adv;
        end

        assign adv = ~v_q | nxt;
        assign res = add_slice(ua[W-1:0], ub[W-1:0], ci, ex, s * W);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                s_q <= '0;
            end else if (adv) begin
                v_q <= vin;
                if (vin) begin
                    c_q <= res[W];
                    s_q <= s_d;
                end
            end
        end

        if (s < STAGES - 1) begin : g_fwd
            logic [RW-1:0] a_q;
            logic [RW-1:0] b_q;
            logic          m_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                    m_q <= 1'b0;
                end else if (adv && vin) begin
                    a_q <= ua[RW+W-1:W];
                    b_q <= ub[RW+W-1:W];
                    m_q <= ex;
                end
            end
        end

`ifdef PIPELINED_APPROX_ADDER_ERR_CNT_EN
        logic [N:0] x_d;
        logic [N:0] x_q;

        if (s == 0) begin : g_xs
            assign x_d = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
        end else begin : g_xs
            assign x_d = g_stg[s-1].x_q;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                x_q <= '0;
            end else if (adv && vin) begin
                x_q <= x_d;
            end
        end
`endif
    end

    assign in_ready  = g_stg[0].adv;
    assign out_valid = g_stg[STAGES-1].v_q;
    assign sum       = g_stg[STAGES-1].s_q;
    assign cout      = g_stg[STAGES-1].c_q;

`ifdef PIPELINED_APPROX_ADDER_ERR_CNT_EN
    logic [N:0] exact_res;
    logic       miss;

    assign exact_res = g_stg[STAGES-1].x_q;
    assign miss      = out_valid & out_ready & ({cout, sum} != exact_res);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= '0;
        end else if (clr_err) begin
            err_count <= '0;
        end else if (miss && err_count != 16'hFFFF) begin
            err_count <= err_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipelined_approx_adder.sv
// Randomised and directed bench for pipelined_approx_adder with a queue scoreboard.
// Exercises err_count too when PIPELINED_APPROX_ADDER_ERR_CNT_EN is defined.
`timescale 1ns/1ps
module tb_pipelined_approx_adder;

    localparam int N  = 16;
    localparam int ST = 2;
    localparam int AL = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [N-1:0] a = '0;
    logic [N-1:0] b = '0;
    logic         cin = 1'b0;
    logic         exact_mode = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [N-1:0] sum;
    logic         cout;
`ifdef PIPELINED_APPROX_ADDER_ERR_CNT_EN
    logic         clr_err = 1'b0;
    logic [15:0]  err_count;
`endif

    int         total = 0;
    int         bad = 0;
    int         waits = 0;
    logic [N:0] exp_q[$];
    logic [N:0] log_q[$];
    logic       stall_prev = 1'b0;
    logic [N:0] held = '0;

    always #5 clk = ~clk;

    pipelined_approx_adder #(
        .N(N),
        .STAGES(ST),
        .APPROX_LSB(AL)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .a(a),
        .b(b),
        .cin(cin),
        .exact_mode(exact_mode),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum(sum),
        .cout(cout)
`ifdef PIPELINED_APPROX_ADDER_ERR_CNT_EN
        ,
        .clr_err(clr_err),
        .err_count(err_count)
`endif
    );

    // Reference: exact add, then each approximate bit is the inverse of its carry-out.
    function automatic logic [N:0] model(
        input logic [N-1:0] x,
        input logic [N-1:0] y,
        input logic         c,
        input logic         ex
    );
        logic [N:0] full;
        logic [N:0] cv;
        full = {1'b0, x} + {1'b0, y} + {{N{1'b0}}, c};
        cv   = full ^ {1'b0, x} ^ {1'b0, y};
        if (!ex) begin
            for (int i = 0; i < AL; i++) full[i] = ~cv[i+1];
        end
        return full;
    endfunction

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("hold_valid", {31'd0, out_valid}, 32'd1);
                check("hold_data", {15'd0, cout, sum}, {15'd0, held});
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out", {15'd0, cout, sum}, 32'hFFFF_FFFF);
                end else begin
                    check("result", {15'd0, cout, sum},
                          {15'd0, exp_q.pop_front()});
                    log_q.push_back({cout, sum});
                end
            end
            if (in_valid && in_ready) exp_q.push_back(model(a, b, cin, exact_mode));
            stall_prev = out_valid && !out_ready;
            held = {cout, sum};
        end
    end

    task automatic send(input logic [N-1:0] x, input logic [N-1:0] y,
                        input logic c, input logic m);
        int w = 0;
        in_valid   = 1'b1;
        a          = x;
        b          = y;
        cin        = c;
        exact_mode = m;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            w++;
            if (w > 50) begin
                total++;
                bad++;
                $display("FAIL send_timeout: waited %0d want <=50", w);
                break;
            end
            @(posedge clk);
            #1;
        end
        waits += w;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int w = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while ((exp_q.size() != 0 || out_valid) && w < 60) begin
            @(posedge clk);
            #1;
            w++;
        end
        check("drain_left", exp_q.size(), 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int cnt;

        check("model_pin_exact", {15'd0, model(16'h1234, 16'h4321, 1'b0, 1'b1)}, 32'h5555);
        check("model_pin_apx0", {15'd0, model(16'h0000, 16'h0000, 1'b0, 1'b0)}, 32'h000F);
        check("model_pin_apx1", {15'd0, model(16'hFFFF, 16'hFFFF, 1'b1, 1'b0)}, 32'h1FFF0);

        repeat (2) @(negedge clk);
        check("rst_out_valid", {31'd0, out_valid}, 0);
        check("rst_sum", {15'd0, cout, sum}, 0);
        rst_n = 1'b1;
        tick();
        @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 1);
        tick();

        // Latency of one exact transaction
        out_ready  = 1'b1;
        in_valid   = 1'b1;
        a          = 16'h1234;
        b          = 16'h4321;
        cin        = 1'b0;
        exact_mode = 1'b1;
        @(negedge clk);
        check("lat_in_ready", {31'd0, in_ready}, 1);
        tick();
        in_valid = 1'b0;
        cnt = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) break;
            tick();
            cnt++;
        end
        check("latency", cnt, ST);
        check("lat_sum", {15'd0, cout, sum}, 32'h5555);
        tick();

        // Approximate vs exact corner operands
        log_q.delete();
        send(16'h0000, 16'h0000, 1'b0, 1'b0);
        send(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
        send(16'h0000, 16'h0000, 1'b0, 1'b1);
        send(16'hFFFF, 16'hFFFF, 1'b1, 1'b1);
        drain();
        check("corner_n", log_q.size(), 4);
        if (log_q.size() == 4) begin
            check("corner0", {15'd0, log_q[0]}, 32'h0000F);
            check("corner1", {15'd0, log_q[1]}, 32'h1FFF0);
            check("corner2", {15'd0, log_q[2]}, 32'h00000);
            check("corner3", {15'd0, log_q[3]}, 32'h1FFFF);
        end

        // Backpressure fills the pipeline
        log_q.delete();
        out_ready = 1'b0;
        send(16'h0001, 16'h0001, 1'b0, 1'b1);
        send(16'h0002, 16'h0002, 1'b0, 1'b1);
        in_valid   = 1'b1;
        a          = 16'h0003;
        b          = 16'h0003;
        exact_mode = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("bp_in_ready", {31'd0, in_ready}, 0);
            tick();
        end
        out_ready = 1'b1;
        send(16'h0003, 16'h0003, 1'b0, 1'b1);
        drain();
        check("bp_n", log_q.size(), 3);
        if (log_q.size() == 3) begin
            check("bp0", {15'd0, log_q[0]}, 32'h2);
            check("bp1", {15'd0, log_q[1]}, 32'h4);
            check("bp2", {15'd0, log_q[2]}, 32'h6);
        end

        // Full throughput
        log_q.delete();
        waits = 0;
        for (int i = 0; i < 8; i++) begin
            send(N'($urandom), N'($urandom), 1'($urandom), 1'($urandom));
        end
        check("tput_waits", waits, 0);
        drain();
        check("tput_n", log_q.size(), 8);

        // Mode change mid-flight
        log_q.delete();
        send(16'h0000, 16'h0000, 1'b0, 1'b0);
        send(16'h0000, 16'h0000, 1'b0, 1'b1);
        drain();
        check("mode_n", log_q.size(), 2);
        if (log_q.size() == 2) begin
            check("mode0", {15'd0, log_q[0]}, 32'hF);
            check("mode1", {15'd0, log_q[1]}, 32'h0);
        end

        // Asynchronous reset with data in flight
        out_ready = 1'b0;
        send(16'h0005, 16'h0006, 1'b0, 1'b1);
        send(16'h0007, 16'h0008, 1'b0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", {31'd0, out_valid}, 0);
        check("arst_sum", {15'd0, cout, sum}, 0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(negedge clk);
        check("arst_in_ready", {31'd0, in_ready}, 1);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            @(negedge clk);
            check("arst_no_stale", {31'd0, out_valid}, 0);
        end
        tick();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 4))
                0: a = '0;
                1: a = '1;
                default: a = N'($urandom);
            endcase
            case ($urandom_range(0, 4))
                0: b = '0;
                1: b = '1;
                default: b = N'($urandom);
            endcase
            cin        = 1'($urandom);
            exact_mode = 1'($urandom);
            tick();
        end
        drain();

`ifdef PIPELINED_APPROX_ADDER_ERR_CNT_EN
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("err_clr0", {16'd0, err_count}, 0);
        send(16'h0000, 16'h0000, 1'b0, 1'b0);
        send(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
        drain();
        tick();
        check("err_two", {16'd0, err_count}, 2);
        send(16'h1234, 16'h4321, 1'b0, 1'b1);
        drain();
        tick();
        check("err_exact", {16'd0, err_count}, 2);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("err_clr", {16'd0, err_count}, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
